// File: rtl/esteira_pkg.sv
// ============================================================================
// Module      : esteira_pkg
// Description : Shared constants for the bottle conveyor controller. Holds the
//               3-bit state encoding, the default box size and watchdog limit,
//               and the state-to-output decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package esteira_pkg;

  // Default configuration
  localparam int c_caixa_tam_def      = 12;
  localparam int c_timeout_ciclos_def = 1000;

  // State encoding (3 bits); codes 101..111 are unused
  localparam logic [2:0] c_st_parado      = 3'b000;
  localparam logic [2:0] c_st_avancando   = 3'b001;
  localparam logic [2:0] c_st_posicionada = 3'b010;
  localparam logic [2:0] c_st_liberando   = 3'b011;
  localparam logic [2:0] c_st_falha       = 3'b100;

  // Belt runs while searching for a bottle and while pushing a full one out
  function automatic logic motor_ligado(input logic [2:0] st);
    return (st == c_st_avancando) || (st == c_st_liberando);
  endfunction

  // Filler may only fill while the bottle is parked
  function automatic logic garrafa_parada(input logic [2:0] st);
    return (st == c_st_posicionada);
  endfunction

endpackage

`default_nettype wire

// File: rtl/esteira_watchdog.sv
// ============================================================================
// Module      : esteira_watchdog
// Description : Stall counter for the conveyor. Clears on request, counts while
//               enabled, and flags expiry once the count reaches
//               TIMEOUT_CICLOS-1 (i.e. on the TIMEOUT_CICLOS-th cycle in a
//               watched state). Saturates at the limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module esteira_watchdog
  import esteira_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = c_timeout_ciclos_def
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expira
);

  localparam int               c_cnt_w = $clog2(TIMEOUT_CICLOS);
  localparam logic [c_cnt_w-1:0] c_lim = c_cnt_w'(TIMEOUT_CICLOS - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  // Expiry is a function of the registered count only
  assign o_expira = i_en && (cnt_q == c_lim);

  // Clear has priority; otherwise count up to the limit and hold there
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != c_lim)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fsm_esteira.sv
// ============================================================================
// Module      : fsm_esteira
// Description : Conveyor controller feeding the bottle filler. Moore FSM that
//               parks a bottle at the fill station, hands it to the filler via
//               GARRAFA_PRESENTE, releases it once full, and counts bottles per
//               box. Optional stall/jam watchdog enabled by defining the macro
//               ESTEIRA_WATCHDOG_EN; without it FALHA is unreachable and
//               ALARME is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_esteira
  import esteira_pkg::*;
#(
  parameter int CAIXA_TAM      = c_caixa_tam_def,
  parameter int TIMEOUT_CICLOS = c_timeout_ciclos_def
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         HABILITA,
  input  logic                         SENSOR_POSICAO,
  input  logic                         GARRAFA_CHEIA,
  output logic                         MOTOR_ESTEIRA,
  output logic                         GARRAFA_PRESENTE,
  output logic [$clog2(CAIXA_TAM)-1:0] CONTADOR_GARRAFAS,
  output logic                         CAIXA_COMPLETA,
  output logic                         ALARME
);

  localparam int                 c_cnt_w   = $clog2(CAIXA_TAM);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CAIXA_TAM - 1);

  // Elaboration-time parameter sanity
  if (CAIXA_TAM < 2) begin : g_chk_caixa
    $error("fsm_esteira: CAIXA_TAM must be >= 2");
  end
  if (TIMEOUT_CICLOS < 2) begin : g_chk_timeout
    $error("fsm_esteira: TIMEOUT_CICLOS must be >= 2");
  end

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;
  logic               caixa_completa_q;
  logic               caixa_completa_d;
  logic               wd_expira;

`ifdef ESTEIRA_WATCHDOG_EN
  logic wd_clr;
  logic wd_en;

  // Count only while waiting on the filler or on the belt to clear the bottle;
  // any state change restarts the count from zero.
  assign wd_en  = (state_q == c_st_posicionada) || (state_q == c_st_liberando);
  assign wd_clr = (state_d != state_q);

  esteira_watchdog #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_watchdog (
    .i_clk   (CLOCK),
    .i_rst_n (RESET),
    .i_clr   (wd_clr),
    .i_en    (wd_en),
    .o_expira(wd_expira)
  );
`else
  assign wd_expira = 1'b0;
`endif

  // State register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= c_st_parado;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HABILITA is deliberately ignored while a bottle is parked
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_parado: begin
        if (HABILITA) begin
          state_d = SENSOR_POSICAO ? c_st_posicionada : c_st_avancando;
        end
      end
      c_st_avancando: begin
        if (SENSOR_POSICAO) begin
          state_d = c_st_posicionada;
        end else if (!HABILITA) begin
          state_d = c_st_parado;
        end
      end
      c_st_posicionada: begin
        // A fill completing on the expiry cycle is still accepted
        if (GARRAFA_CHEIA) begin
          state_d = c_st_liberando;
        end else if (wd_expira) begin
          state_d = c_st_falha;
        end
      end
      c_st_liberando: begin
        // Bottle clearing the station wins over a coincident jam timeout
        if (!SENSOR_POSICAO) begin
          state_d = HABILITA ? c_st_avancando : c_st_parado;
        end else if (wd_expira) begin
          state_d = c_st_falha;
        end
      end
`ifdef ESTEIRA_WATCHDOG_EN
      c_st_falha: begin
        if (!HABILITA) begin
          state_d = c_st_parado;
        end
      end
`endif
      default: begin
        state_d = c_st_parado;
      end
    endcase
  end

  // Moore output decode from the state register only
  always_comb begin
    MOTOR_ESTEIRA    = motor_ligado(state_q);
    GARRAFA_PRESENTE = garrafa_parada(state_q);
`ifdef ESTEIRA_WATCHDOG_EN
    ALARME           = (state_q == c_st_falha);
`else
    ALARME           = 1'b0;
`endif
  end

  // Box counter advances as a released bottle leaves the station
  always_comb begin
    cnt_d            = cnt_q;
    caixa_completa_d = 1'b0;
    if ((state_q == c_st_liberando) && !SENSOR_POSICAO) begin
      if (cnt_q == c_cnt_max) begin
        cnt_d            = '0;
        caixa_completa_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Box counter and box-complete pulse registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_q            <= '0;
      caixa_completa_q <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      caixa_completa_q <= caixa_completa_d;
    end
  end

  assign CONTADOR_GARRAFAS = cnt_q;
  assign CAIXA_COMPLETA    = caixa_completa_q;

endmodule

`default_nettype wire
